// File: rtl/dive_scheduler.sv
// dive_scheduler
// Decides when the next enemy leaves formation and which one. After a
// random number of frames it scans the alive mask from a random start slot,
// offers the first live slot to the dive unit over valid/ready, then holds
// off until that dive reports completion. Only one dive is in flight.
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous, active-high reset (aborts any dive)
//   i_frame_tick  one-cycle pulse per video frame
//   i_enable      gameplay active
//   i_rnd         16-bit LFSR word
//   i_alive       bit i set = enemy i in formation and eligible to dive
//   o_dive_valid  dive request pending
//   o_dive_id     enemy selected to dive
//   i_dive_ready  dive unit accepts the request
//   i_dive_done   one-cycle pulse when the accepted dive finishes
//   o_busy        high while a request is offered or a dive is in flight
//
// Optional build macro DIVE_SCHED_STATS_EN adds:
//   o_dive_count       accepted handshakes, saturating at 16'hFFFF
//   o_scan_miss_count  full scans that found nobody, saturating at 8'hFF

module dive_scheduler #(
  parameter int N_ENEMIES  = 16,
  parameter int MIN_DELAY  = 32,
  parameter int DELAY_BITS = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_frame_tick,
  input  logic                         i_enable,
  input  logic [15:0]                  i_rnd,
  input  logic [N_ENEMIES-1:0]         i_alive,
  output logic                         o_dive_valid,
  output logic [$clog2(N_ENEMIES)-1:0] o_dive_id,
  input  logic                         i_dive_ready,
  input  logic                         i_dive_done,
  output logic                         o_busy
`ifdef DIVE_SCHED_STATS_EN
  ,
  output logic [15:0]                  o_dive_count,
  output logic [7:0]                   o_scan_miss_count
`endif
);

  localparam int IDW = $clog2(N_ENEMIES);
  localparam int DW  = $clog2(MIN_DELAY + 2**DELAY_BITS) + 1;
  localparam logic [DW-1:0]  MIN_DELAY_W = DW'(MIN_DELAY);
  localparam logic [IDW-1:0] LAST_K      = IDW'(N_ENEMIES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SELECT,
    ST_ISSUE,
    ST_DIVING
  } state_t;

  state_t         r_state;
  logic [DW-1:0]  r_delay;
  logic [IDW-1:0] r_scanIdx;
  logic [IDW-1:0] r_scanCnt;
  logic           r_valid;
  logic           r_busy;
  logic [IDW-1:0] r_diveId;

  logic [DW-1:0]  w_delayLoad;
  logic [IDW-1:0] w_testIdx;
  logic           w_hit;
  logic           w_accept;
  logic           w_scanFail;
  logic           w_unusedRnd;

  // Only the low DELAY_BITS and top IDW bits of the LFSR word matter.
  assign w_unusedRnd = ^i_rnd;

  // Random frame delay, always at least MIN_DELAY; the width leaves headroom
  // so the sum cannot overflow.
  assign w_delayLoad = MIN_DELAY_W + {{(DW-DELAY_BITS){1'b0}}, i_rnd[DELAY_BITS-1:0]};

  // The first scan cycle takes its start slot straight from the LFSR;
  // later cycles continue from the registered index. Power-of-two slot
  // count makes the natural wrap of the index the modulo.
  assign w_testIdx  = (r_scanCnt == '0) ? i_rnd[15 -: IDW] : r_scanIdx;
  assign w_hit      = i_alive[w_testIdx];
  assign w_accept   = (r_state == ST_ISSUE) && i_dive_ready;
  assign w_scanFail = (r_state == ST_SELECT) && i_enable && !w_hit && (r_scanCnt == LAST_K);

  // Main scheduler FSM. Reset wins over everything; the scan counter
  // returns to zero whenever the FSM is not actively scanning so every
  // entry to SELECT starts a fresh scan.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_delay   <= '0;
      r_scanIdx <= '0;
      r_scanCnt <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_diveId  <= '0;
    end else begin
      r_scanCnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_delay <= w_delayLoad;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
          end else if (r_delay == '0) begin
            r_state <= ST_SELECT;
          end else if (i_frame_tick) begin
            r_delay <= r_delay - DW'(1);
          end
        end
        ST_SELECT: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
          end else if (w_hit) begin
            r_diveId <= w_testIdx;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_ISSUE;
          end else if (w_scanFail) begin
            r_delay <= w_delayLoad;
            r_state <= ST_WAIT;
          end else begin
            r_scanCnt <= r_scanCnt + IDW'(1);
            r_scanIdx <= w_testIdx + IDW'(1);
          end
        end
        ST_ISSUE: begin
          // Acceptance beats a same-cycle withdrawal reason.
          if (w_accept) begin
            r_valid <= 1'b0;
            r_state <= ST_DIVING;
          end else if (!i_enable) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (!i_alive[r_diveId]) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_SELECT;
          end
        end
        ST_DIVING: begin
          if (i_dive_done) begin
            r_busy  <= 1'b0;
            r_delay <= w_delayLoad;
            r_state <= i_enable ? ST_WAIT : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dive_valid = r_valid;
  assign o_dive_id    = r_diveId;
  assign o_busy       = r_busy;

`ifdef DIVE_SCHED_STATS_EN
  logic [15:0] r_diveCount;
  logic [7:0]  r_scanMissCount;

  // Saturating activity counters for tuning difficulty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_diveCount     <= '0;
      r_scanMissCount <= '0;
    end else begin
      if (w_accept && (r_diveCount != 16'hFFFF)) begin
        r_diveCount <= r_diveCount + 16'd1;
      end
      if (w_scanFail && (r_scanMissCount != 8'hFF)) begin
        r_scanMissCount <= r_scanMissCount + 8'd1;
      end
    end
  end

  assign o_dive_count      = r_diveCount;
  assign o_scan_miss_count = r_scanMissCount;
`endif

endmodule

// File: tb/tb_dive_scheduler.sv
// tb_dive_scheduler
// Directed bench for dive_scheduler with N_ENEMIES=16, MIN_DELAY=4,
// DELAY_BITS=2. A behavioural model tracks the scheduler in frame and slot
// terms and is compared against the outputs every cycle; literal checks at
// key points pin the model to hand-derived values.

module tb_dive_scheduler;

  localparam int NE   = 16;
  localparam int MIND = 4;
  localparam int DB   = 2;
  localparam int IDW  = 4;

  logic           clk;
  logic           rst;
  logic           frameTick;
  logic           enable;
  logic [15:0]    rnd;
  logic [NE-1:0]  alive;
  logic           diveValid;
  logic [IDW-1:0] diveId;
  logic           diveReady;
  logic           diveDone;
  logic           busy;
`ifdef DIVE_SCHED_STATS_EN
  logic [15:0]    diveCount;
  logic [7:0]     scanMissCount;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int n;
  int seen;

  dive_scheduler #(
    .N_ENEMIES (NE),
    .MIN_DELAY (MIND),
    .DELAY_BITS(DB)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_frame_tick     (frameTick),
    .i_enable         (enable),
    .i_rnd            (rnd),
    .i_alive          (alive),
    .o_dive_valid     (diveValid),
    .o_dive_id        (diveId),
    .i_dive_ready     (diveReady),
    .i_dive_done      (diveDone),
    .o_busy           (busy)
`ifdef DIVE_SCHED_STATS_EN
    ,
    .o_dive_count     (diveCount),
    .o_scan_miss_count(scanMissCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model of the scheduler: frames left to wait, slots tried so far in the
  // current scan, and the request/dive phase.
  typedef enum int {M_IDLE, M_WAIT, M_SELECT, M_ISSUE, M_DIVING} modelPhase_t;
  modelPhase_t mPhase = M_IDLE;
  int  mFrames = 0;
  int  mStart  = 0;
  int  mTried  = 0;
  int  mId     = 0;
  bit  mValid  = 1'b0;
  bit  mBusy   = 1'b0;
  int  mDives  = 0;
  int  mMisses = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic int randomDelay();
    return MIND + (int'(rnd) % (2**DB));
  endfunction

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic modelStep();
    int slot;
    if (rst) begin
      mPhase = M_IDLE; mFrames = 0; mTried = 0; mId = 0;
      mValid = 1'b0; mBusy = 1'b0; mDives = 0; mMisses = 0;
    end else begin
      case (mPhase)
        M_IDLE: begin
          if (enable) begin
            mFrames = randomDelay();
            mPhase  = M_WAIT;
          end
        end
        M_WAIT: begin
          if (!enable) mPhase = M_IDLE;
          else if (mFrames == 0) begin
            mPhase = M_SELECT;
            mTried = 0;
          end else if (frameTick) mFrames = mFrames - 1;
        end
        M_SELECT: begin
          if (!enable) mPhase = M_IDLE;
          else begin
            if (mTried == 0) mStart = int'(rnd) / (2**(16-IDW));
            slot = (mStart + mTried) % NE;
            if (alive[slot]) begin
              mId = slot; mValid = 1'b1; mBusy = 1'b1; mPhase = M_ISSUE;
            end else if (mTried == NE - 1) begin
              if (mMisses < 255) mMisses = mMisses + 1;
              mFrames = randomDelay();
              mPhase  = M_WAIT;
            end else mTried = mTried + 1;
          end
        end
        M_ISSUE: begin
          if (diveReady) begin
            mValid = 1'b0; mPhase = M_DIVING;
            if (mDives < 65535) mDives = mDives + 1;
          end else if (!enable) begin
            mValid = 1'b0; mBusy = 1'b0; mPhase = M_IDLE;
          end else if (!alive[mId]) begin
            mValid = 1'b0; mBusy = 1'b0; mPhase = M_SELECT; mTried = 0;
          end
        end
        M_DIVING: begin
          if (diveDone) begin
            mBusy   = 1'b0;
            mFrames = randomDelay();
            mPhase  = enable ? M_WAIT : M_IDLE;
          end
        end
        default: mPhase = M_IDLE;
      endcase
    end
  endtask

  // Every-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      modelStep();
      checkOutput("dive_valid", diveValid, mValid);
      checkOutput("dive_id", diveId, mId);
      checkOutput("busy", busy, mBusy);
`ifdef DIVE_SCHED_STATS_EN
      checkOutput("dive_count", diveCount, mDives);
      checkOutput("scan_miss_count", scanMissCount, mMisses);
`endif
    end
  end

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int count);
    repeat (count) begin
      frameTick = 1'b1;
      step(1);
    end
    frameTick = 1'b0;
  endtask

  task automatic waitValid(input int limit, output int taken);
    taken = 0;
    while ((diveValid !== 1'b1) && (taken < limit)) begin
      step(1);
      taken++;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en, input logic rdy, input logic dn,
                               input logic [15:0] rv, input logic [15:0] al);
    rst = r; enable = en; diveReady = rdy; diveDone = dn; rnd = rv; alive = al;
    frameTick = 1'b0;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    step(2);
    checkOutput("reset dive_valid", diveValid, 0);
    checkOutput("reset dive_id", diveId, 0);
    checkOutput("reset busy", busy, 0);

    // First dive: delay 4+3 frames, start slot 0.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0003, 16'hFFFF);
    step(1);
    for (int i = 0; i < 6; i++) begin
      ticks(1);
      step(2);
    end
    step(5);
    checkOutput("no dive after 6 ticks", diveValid, 0);
    ticks(1);
    waitValid(6, n);
    checkOutput("cycles from 7th tick to valid", n, 2);
    checkOutput("first dive_id", diveId, 0);
    checkOutput("busy while issuing", busy, 1);
    step(1);
    checkOutput("valid is a single-cycle pulse", diveValid, 0);
    checkOutput("busy while diving", busy, 1);
    step(3);
    checkOutput("busy until done", busy, 1);

    // Wrapping scan: start 10, only slot 3 alive.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'hA000, 16'h0008);
    step(1);
    diveDone = 1'b0;
    checkOutput("busy clears on done", busy, 0);
    ticks(4);
    step(1);
    waitValid(30, n);
    checkOutput("wrapped scan length", n, 10);
    checkOutput("wrapped scan dive_id", diveId, 3);
    step(3);
    checkOutput("valid held without ready", diveValid, 1);
    checkOutput("dive_id held without ready", diveId, 3);
    diveReady = 1'b1;
    step(1);
    diveReady = 1'b0;

    // Withdrawal on alive drop, then ready beats a simultaneous drop.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 16'h5000, 16'h0120);
    step(1);
    diveDone = 1'b0;
    ticks(4);
    waitValid(6, n);
    checkOutput("slot 5 selected latency", n, 2);
    checkOutput("slot 5 selected", diveId, 5);
    step(2);
    alive = 16'h0100;
    step(1);
    checkOutput("withdraw on alive drop", diveValid, 0);
    checkOutput("busy clears on withdraw", busy, 0);
    waitValid(20, n);
    checkOutput("rescan length", n, 4);
    checkOutput("rescan picks next alive", diveId, 8);
    alive = 16'h0000;
    diveReady = 1'b1;
    step(1);
    diveReady = 1'b0;
    checkOutput("ready beats alive drop valid", diveValid, 0);
    checkOutput("ready beats alive drop busy", busy, 1);

    // Empty formation: a full 16-slot scan finds nobody, delay reloads to 4.
    rnd = 16'h0000;
    diveDone = 1'b1;
    step(1);
    diveDone = 1'b0;
    ticks(4);
    step(1);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      seen += int'(diveValid);
    end
    checkOutput("no request with empty formation", seen, 0);
`ifdef DIVE_SCHED_STATS_EN
    checkOutput("scan_miss_count after empty scan", scanMissCount, 1);
`endif
    alive = 16'hFFFF;
    step(6);
    checkOutput("back in wait without ticks", diveValid, 0);
    ticks(3);
    step(3);
    checkOutput("reloaded delay is 4 not 3", diveValid, 0);
    ticks(1);
    waitValid(6, n);
    checkOutput("dive after reloaded delay", n, 2);

    // Enable drop during ISSUE and during DIVING.
    enable = 1'b0;
    step(1);
    checkOutput("enable drop withdraws valid", diveValid, 0);
    checkOutput("enable drop clears busy", busy, 0);
    enable = 1'b1;
    step(1);
    ticks(4);
    waitValid(6, n);
    checkOutput("dive after re-enable", n, 2);
    diveReady = 1'b1;
    step(1);
    diveReady = 1'b0;
    enable = 1'b0;
    step(3);
    checkOutput("enable drop ignored while diving", busy, 1);
    diveDone = 1'b1;
    step(1);
    diveDone = 1'b0;
    checkOutput("done with enable low clears busy", busy, 0);
    enable = 1'b1;
    rnd = 16'h7003;
    step(1);
    ticks(4);
    step(3);
    checkOutput("done with enable low went idle", diveValid, 0);
    ticks(3);
    waitValid(6, n);
    checkOutput("fresh delay of 7 after idle", n, 2);
    checkOutput("start slot 7", diveId, 7);

    // Reset during DIVING, then during WAIT with three frames left.
    diveReady = 1'b1;
    step(1);
    diveReady = 1'b0;
    checkOutput("diving before reset", busy, 1);
    rst = 1'b1;
    step(1);
    checkOutput("reset in diving valid", diveValid, 0);
    checkOutput("reset in diving dive_id", diveId, 0);
    checkOutput("reset in diving busy", busy, 0);
    rst = 1'b0;
    enable = 1'b0;
    diveDone = 1'b1;
    step(1);
    diveDone = 1'b0;
    step(2);
    checkOutput("stray done ignored", busy, 0);
    enable = 1'b1;
    rnd = 16'h0000;
    step(1);
    ticks(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("reset in wait valid", diveValid, 0);
    checkOutput("reset in wait busy", busy, 0);
    diveDone = 1'b1;
    step(1);
    diveDone = 1'b0;
    checkOutput("done after reset ignored", busy, 0);
    ticks(4);
    waitValid(6, n);
    checkOutput("dive after reset", n, 2);
    diveReady = 1'b1;
    step(1);
    diveReady = 1'b0;
    checkOutput("accepted after reset", busy, 1);
`ifdef DIVE_SCHED_STATS_EN
    checkOutput("dive_count cleared by reset", diveCount, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
